clk_div_monitor: RTL and testbench

//  Downstream checker for the divided clock from clk_div_5 (or any clk_div_N).

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/edge_sampler.sv | 31 +++
 rtl/clk_div_monitor.sv | 171 +++++++++++++++++
 tb/tb_clk_div_monitor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and duty-window helpers for divided-clock monitors.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2
  } mon_state_t;

  // Legal sampled-high window for a divide-by-n clock; odd n allows either
  // floor or ceiling of n/2 depending on sampling phase.
  function automatic int unsigned hi_min(input int unsigned n);
    return n / 2;
  endfunction

  function automatic int unsigned hi_max(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/edge_sampler.sv
// Two-stage sampler of a same-domain signal with rise/fall strobes
// derived from the registered history.
module edge_sampler (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_d;

  // NOTE: non-blocking assignments make r_d take the old r_q, forming a true
  // two-stage shift; blocking would collapse both stages into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 1'b0;
      r_d <= 1'b0;
    end else begin
      r_q <= i_din;
      r_d <= r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_q & ~r_d;
  assign o_fall = ~r_q & r_d;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled in the source
// clock domain; flags period/duty errors, a stuck divider and lock.
module clk_div_monitor #(
  parameter int unsigned DIV_N   = 5,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             period_err,
  output logic             duty_err,
  output logic             stuck,
  output logic             lock
);
  import clk_div_pkg::*;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DIV_N_C   = CNT_W'(DIV_N);
  localparam logic [CNT_W-1:0] HI_MIN    = CNT_W'(hi_min(DIV_N));
  localparam logic [CNT_W-1:0] HI_MAX    = CNT_W'(hi_max(DIV_N));

  mon_state_t       r_state;
  mon_state_t       w_state_next;
  logic             w_div_q;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_idle_expired;
  logic             w_timeout;
  logic             w_start;
  logic             w_meas;
  logic             w_period_bad;
  logic             w_duty_bad;
  logic [1:0]       w_good_next;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [1:0]       r_good_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_cnt;
  logic             r_meas_valid;
  logic             r_period_err;
  logic             r_duty_err;
  logic             r_stuck;
  logic             r_lock;

  edge_sampler u_sampler (
    .clk    (clk),
    .rst    (rst),
    .i_din  (div_in),
    .o_q    (w_div_q),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_edge         = w_rise | w_fall;
  assign w_idle_expired = !w_edge && (r_idle_cnt == IDLE_LAST);
  assign w_period_bad   = (r_cyc_cnt != DIV_N_C);
  assign w_duty_bad     = (r_hi_cnt < HI_MIN) || (r_hi_cnt > HI_MAX);
  assign w_good_next    = (r_good_cnt == 2'd2) ? 2'd2 : r_good_cnt + 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    w_start      = 1'b0;
    w_meas       = 1'b0;
    if (!en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_next = SYNC;
        SYNC: begin
          if (w_idle_expired) begin
            w_timeout = 1'b1;
          end else if (w_rise) begin
            w_start      = 1'b1;
            w_state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (w_idle_expired) begin
            w_timeout    = 1'b1;
            w_state_next = SYNC;
          end else if (w_rise) begin
            w_meas  = 1'b1;
            w_start = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Measurement outputs survive a disable; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_idle_cnt   <= '0;
      r_good_cnt   <= 2'd0;
      r_period     <= '0;
      r_high_cnt   <= '0;
      r_meas_valid <= 1'b0;
      r_period_err <= 1'b0;
      r_duty_err   <= 1'b0;
      r_stuck      <= 1'b0;
      r_lock       <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      if (!en || r_state == IDLE) begin
        r_cyc_cnt  <= '0;
        r_hi_cnt   <= '0;
        r_idle_cnt <= '0;
        r_good_cnt <= 2'd0;
        r_stuck    <= 1'b0;
        r_lock     <= 1'b0;
      end else begin
        r_idle_cnt <= (w_edge || w_timeout) ? '0 : r_idle_cnt + ONE;
        if (w_start) begin
          r_cyc_cnt <= ONE;
          r_hi_cnt  <= ONE;
        end else begin
          r_cyc_cnt <= (r_cyc_cnt == CNT_MAX) ? CNT_MAX : r_cyc_cnt + ONE;
          r_hi_cnt  <= (w_div_q && r_hi_cnt != CNT_MAX) ? r_hi_cnt + ONE : r_hi_cnt;
        end
        if (w_timeout) begin
          r_stuck    <= 1'b1;
          r_lock     <= 1'b0;
          r_good_cnt <= 2'd0;
        end
        if (w_meas) begin
          r_period     <= r_cyc_cnt;
          r_high_cnt   <= r_hi_cnt;
          r_period_err <= w_period_bad;
          r_duty_err   <= w_duty_bad;
          r_meas_valid <= 1'b1;
          if (w_period_bad || w_duty_bad) begin
            r_good_cnt <= 2'd0;
            r_lock     <= 1'b0;
          end else begin
            r_good_cnt <= w_good_next;
            r_lock     <= (w_good_next == 2'd2);
          end
        end
      end
    end
  end

  assign period     = r_period;
  assign high_cnt   = r_high_cnt;
  assign meas_valid = r_meas_valid;
  assign period_err = r_period_err;
  assign duty_err   = r_duty_err;
  assign stuck      = r_stuck;
  assign lock       = r_lock;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor: a timestamp-based model of the
// sampled div_in history, an every-cycle compare, and pinned literal values.
module tb_clk_div_monitor;

  localparam int DIV_N   = 5;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 64;

  logic             clk    = 1'b0;
  logic             rst    = 1'b0;
  logic             div_in = 1'b0;
  logic             en     = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_valid;
  logic             period_err;
  logic             duty_err;
  logic             stuck;
  logic             lock;

  int n_cmp = 0;
  int n_bad = 0;
  int pc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 1;

  clk_div_monitor #(.DIV_N(DIV_N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_in     (div_in),
    .en         (en),
    .period     (period),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .period_err (period_err),
    .duty_err   (duty_err),
    .stuck      (stuck),
    .lock       (lock)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: hist[k] is the div_in value taken at monitor edge k; indices at or
  // below floor_k predate the last reset and read as 0. A measurement is the
  // distance between two rise timestamps and the ones counted between them.
  int hist [0:8191];
  int mk      = 0;
  int floor_k = 0;
  bit m_active, m_synced;
  int m_last_edge, m_rise_k, m_good;
  int m_period, m_high;
  bit m_mv, m_perr, m_derr, m_stuck, m_lock;

  function automatic int s(input int i);
    return (i <= floor_k) ? 0 : hist[i];
  endfunction

  initial begin
    bit rs, ed;
    int hsum;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        floor_k  = mk;
        m_active = 0; m_synced = 0; m_good = 0;
        m_period = 0; m_high = 0;
        m_mv = 0; m_perr = 0; m_derr = 0; m_stuck = 0; m_lock = 0;
      end else begin
        mk++;
        hist[mk] = div_in;
        rs   = s(mk - 1) == 1 && s(mk - 2) == 0;
        ed   = s(mk - 1) != s(mk - 2);
        m_mv = 0;
        if (!en) begin
          m_active = 0; m_synced = 0; m_lock = 0; m_stuck = 0; m_good = 0;
        end else if (!m_active) begin
          m_active = 1; m_synced = 0; m_last_edge = mk;
        end else if (!ed && mk - m_last_edge == TIMEOUT) begin
          m_stuck = 1; m_lock = 0; m_good = 0; m_synced = 0; m_last_edge = mk;
        end else begin
          if (ed) m_last_edge = mk;
          if (rs) begin
            if (m_synced) begin
              hsum = 0;
              for (int i = m_rise_k - 1; i <= mk - 2; i++) hsum += s(i);
              m_period = mk - m_rise_k;
              m_high   = hsum;
              m_perr   = (m_period != DIV_N);
              m_derr   = (hsum < DIV_N / 2) || (hsum > (DIV_N + 1) / 2);
              m_mv     = 1;
              if (m_perr || m_derr) m_good = 0;
              else                  m_good++;
              m_lock   = (m_good >= 2);
            end
            m_synced = 1;
            m_rise_k = mk;
          end
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("period",     period,     m_period);
      check("high_cnt",   high_cnt,   m_high);
      check("meas_valid", meas_valid, m_mv);
      check("period_err", period_err, m_perr);
      check("duty_err",   duty_err,   m_derr);
      check("stuck",      stuck,      m_stuck);
      check("lock",       lock,       m_lock);
    end
  end

  // Record of every meas_valid pulse, for literal expectations.
  int cap_p [64], cap_h [64], cap_pe [64], cap_de [64], cap_lk [64], cap_pc [64];
  int nm       = 0;
  int stuck_pc = -1;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (meas_valid && nm < 64) begin
        cap_p[nm]  = period;
        cap_h[nm]  = high_cnt;
        cap_pe[nm] = period_err;
        cap_de[nm] = duty_err;
        cap_lk[nm] = lock;
        cap_pc[nm] = pc;
        nm++;
      end
      if (stuck && stuck_pc < 0) stuck_pc = pc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input logic v);
    @(posedge clk);
    #1;
    div_in = v;
  endtask

  task automatic pat(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1);
      for (int i = 0; i < lo; i++) cyc(1'b0);
    end
  endtask

  initial begin
    int mark, mark_hold, nm0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_period", period, 0);
    check("reset_high",   high_cnt, 0);
    check("reset_valid",  meas_valid, 0);
    check("reset_lock",   lock, 0);
    check("reset_stuck",  stuck, 0);
    rst = 1'b1;
    en  = 1'b1;

    // Good divide-by-5 (3 high / 2 low): sync on 1st rise, measure from 2nd.
    pat(3, 2, 1);
    cyc(1'b1);
    mark = pc;
    cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);
    pat(3, 2, 2);
    pat(3, 3, 3);   // period 6
    pat(3, 2, 3);   // relock
    pat(1, 4, 2);   // duty 1/5
    pat(3, 2, 3);   // relock
    cyc(1'b1);      // final rise, then hold high
    mark_hold = pc;
    repeat (79) cyc(1'b1);

    check("meas_count",  nm, 15);
    check("m0_latency",  cap_pc[0] - mark, 2);
    check("m0_period",   cap_p[0], 5);
    check("m0_high",     cap_h[0], 3);
    check("m0_perr",     cap_pe[0], 0);
    check("m0_derr",     cap_de[0], 0);
    check("m0_lock",     cap_lk[0], 0);
    check("m1_lock",     cap_lk[1], 1);
    check("m4_period",   cap_p[4], 6);
    check("m4_high",     cap_h[4], 3);
    check("m4_perr",     cap_pe[4], 1);
    check("m4_derr",     cap_de[4], 0);
    check("m4_lock",     cap_lk[4], 0);
    check("m9_lock",     cap_lk[9], 1);
    check("m10_period",  cap_p[10], 5);
    check("m10_high",    cap_h[10], 1);
    check("m10_perr",    cap_pe[10], 0);
    check("m10_derr",    cap_de[10], 1);
    check("m10_lock",    cap_lk[10], 0);
    check("m14_lock",    cap_lk[14], 1);
    // Edge taken at mark+1, seen by the FSM at mark+2, then TIMEOUT cycles.
    check("stuck_delay", stuck_pc - mark_hold, 2 + TIMEOUT);
    check("hold_stuck",  stuck, 1);
    check("hold_lock",   lock, 0);

    // Toggling again does not clear stuck; an enable cycle does.
    pat(3, 2, 4);
    check("resume_stuck", stuck, 1);
    en = 1'b0;
    cyc(1'b0);
    en = 1'b1;
    cyc(1'b0);
    check("reen_stuck", stuck, 0);

    // Disable mid-period: lock drops, last measurement retained.
    pat(3, 2, 4);
    cyc(1'b1); cyc(1'b1); cyc(1'b1); cyc(1'b0);
    check("pre_dis_lock", lock, 1);
    cyc(1'b0); cyc(1'b1);
    nm0 = nm;
    en  = 1'b0;
    cyc(1'b1);
    pat(3, 2, 2);
    check("dis_lock",   lock, 0);
    check("dis_period", period, 5);
    check("dis_high",   high_cnt, 3);
    check("dis_nmeas",  nm - nm0, 0);
    en = 1'b1;
    pat(3, 2, 3);
    cyc(1'b0);
    check("reen_nmeas", nm - nm0, 2);

    // Asynchronous reset mid-period clears outputs before the next edge.
    pat(3, 2, 2);
    cyc(1'b1); cyc(1'b1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_period", period, 0);
    check("arst_high",   high_cnt, 0);
    check("arst_lock",   lock, 0);
    check("arst_perr",   period_err, 0);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    rst = 1'b1;
    nm0 = nm;
    pat(3, 2, 1);
    cyc(1'b1);
    check("post_rst_none", nm - nm0, 0);
    cyc(1'b1); cyc(1'b1); cyc(1'b0);
    check("post_rst_one",  nm - nm0, 1);
    pat(3, 2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
